mm_cmd_scheduler: RTL and testbench
===================================

Name: mm_cmd_scheduler

Overview:
- Arbitrates TPM command requests from NUM_REQ requesters (locality/interface front-ends) onto the single management_module command port.
- Drives the active-low keyStart strobe, command code, parameters and locality for each command.
- Waits a fixed settle time, captures the response code and returns it to the granted requester.
- Sits between the host-interface decoders and management_module. Optionally short-circuits commands the TPM must reject in failure mode.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_CYC, 2, cycles mm_keyStart_n_o is held low per command (>=1).
- SETTLE_CYC, 2, cycles after keyStart release before mm_rc_i is sampled (>=1).

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester command pending
- req_cc_i  in  NUM_REQ*32  command codes; requester k occupies bits [32k+31:32k]
- req_param_i  in  NUM_REQ*33  command parameters; requester k occupies [33k+32:33k]
- req_locality_i  in  NUM_REQ*8  localities; requester k occupies [8k+7:8k]
- req_ready_o  out  NUM_REQ  one-hot, 1-cycle accept pulse
- resp_valid_o  out  1  response available
- resp_id_o  out  $clog2(NUM_REQ)  requester index the response belongs to
- resp_rc_o  out  32  response code
- resp_ready_i  in  1  response consumer accepts
- mm_keyStart_n_o  out  1  management_module command strobe, active low
- mm_cc_o  out  32  command code to management_module
- mm_param_o  out  33  parameters to management_module
- mm_locality_o  out  8  locality to management_module
- mm_rc_i  in  32  management_module tpm_rc
- mm_op_state_i  in  3  management_module op_state (3'b101 = FAILURE_MODE)
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - req_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_rc_o=0.
  - mm_keyStart_n_o=1, mm_cc_o=0, mm_param_o=0, mm_locality_o=0, busy_o=0.
  - Round-robin pointer=0; FSM=IDLE.
- FSM states:
  - IDLE: if any req_valid_i, grant by round robin, starting at the pointer and searching upward with wrap. Pulse req_ready_o[g] for 1 cycle. Latch cc/param/locality of requester g into the mm_* outputs. Set pointer=g+1 (mod NUM_REQ). Go to STROBE.
  - STROBE: mm_keyStart_n_o=0 for exactly START_CYC cycles, then 1. Go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles; on the last cycle register mm_rc_i into resp_rc_o, set resp_id_o=g and resp_valid_o=1. Go to RESP.
  - RESP: hold resp_valid_o/resp_id_o/resp_rc_o stable until resp_valid_o&&resp_ready_i. Then clear resp_valid_o and go to IDLE.
- Grant timing:
  - Minimum latency from req_valid_i high in IDLE to resp_valid_o high is 1+START_CYC+SETTLE_CYC cycles.
  - No new grant while busy; only one command is in flight.
  - Back-to-back: a request seen in the IDLE cycle after RESP exits is granted in that cycle.
- Request and output stability:
  - Requesters hold req_valid_i and data until req_ready_o.
  - Data is latched at grant; later changes are ignored.
  - mm_cc_o/mm_param_o/mm_locality_o stay stable from grant until the next grant. They are not cleared between commands.
- Simultaneous requests: all valid in the same cycle are served in pointer order, with no starvation. With NUM_REQ requesters permanently valid, each is served once every NUM_REQ commands.
- req_valid_i dropping before grant: the request is withdrawn, with no side effect.
- Reset mid-command:
  - All outputs return to reset values immediately (async); mm_keyStart_n_o goes 1 even mid-strobe.
  - The in-flight command is abandoned; no response is issued.
- resp_ready_i high while resp_valid_o=0: ignored.

Optional Feature:
- Macro MM_SCHED_FAILGATE_EN.
- Defined: in IDLE, if mm_op_state_i==3'b101 at grant and the granted cc is not 32'h0000017C (GetTestResult) or 32'h0000017A (GetCapability), the command is blocked:
  - No strobe is issued; mm_* command outputs keep their previous values.
  - The FSM goes directly to RESP next cycle with resp_rc_o=32'h00000101 (TPM_RC_FAILURE).
  - The arbiter pointer still advances.
- Undefined: every granted command is strobed regardless of op_state.

Decomposition:
- Shared package mm_sched_pkg:
  - FSM state encoding (IDLE, STROBE, SETTLE, RESP).
  - Constants CC_GET_TEST_RESULT=32'h17C, CC_GET_CAPABILITY=32'h17A, RC_FAILURE=32'h101, OPSTATE_FAILURE=3'b101.
- One sub-module, mm_rr_arbiter: combinational round-robin grant (request vector plus pointer in, one-hot grant plus index out). It is reused by other shared-resource controllers.

Test Plan:
- Single command: reset; req_valid_i[0]=1, cc=32'h144, param=0, locality=8'h01 → req_ready_o=4'b0001. mm_keyStart_n_o is low for 2 cycles. resp_valid_o is high 5 cycles after the request with resp_id_o=0 and resp_rc_o equal to mm_rc_i (tie 32'h0).
- Fairness: all four req_valid_i held high, resp_ready_i=1 → grant order 0,1,2,3,0,1. Each requester's cc appears on mm_cc_o during its own strobe.
- Response backpressure: resp_ready_i=0 for 10 cycles → resp_valid_o/resp_rc_o stay stable and req_ready_o stays 0 while requesters 1 and 2 wait. Raise resp_ready_i → next grant goes to requester 1.
- Reset during STROBE: assert reset_i while mm_keyStart_n_o=0 → mm_keyStart_n_o=1 and busy_o=0 at once, with no response. After release, a new request is granted from pointer 0.
- Failure gate (macro defined): mm_op_state_i=3'b101, request cc=32'h131 → no strobe, resp_rc_o=32'h101. Then request cc=32'h17C → a strobe is issued and resp_rc_o=mm_rc_i (tie 32'hFFFFFFFF).
- Failure gate (macro undefined): same stimulus with cc=32'h131 → strobe issued, resp_rc_o=32'hFFFFFFFF.

Source files
------------

// File: rtl/mm_sched_pkg.sv
// rtl/mm_sched_pkg.sv - shared FSM encoding and TPM constants for mm_cmd_scheduler
package mm_sched_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [31:0] CC_GET_TEST_RESULT = 32'h0000017C;
  localparam logic [31:0] CC_GET_CAPABILITY  = 32'h0000017A;
  localparam logic [31:0] RC_FAILURE         = 32'h00000101;
  localparam logic [2:0]  OPSTATE_FAILURE    = 3'b101;

  // Commands the TPM must still execute while in failure mode.
  function automatic logic fail_exempt(input logic [31:0] cc);
    return (cc == CC_GET_TEST_RESULT) || (cc == CC_GET_CAPABILITY);
  endfunction

endpackage

// File: rtl/mm_rr_arbiter.sv
// rtl/mm_rr_arbiter.sv - combinational round-robin grant, searching upward from ptr_i with wrap
module mm_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/mm_cmd_scheduler.sv
// rtl/mm_cmd_scheduler.sv - arbitrates requesters onto the management_module command port
// Optional failure-mode gating is enabled with `define MM_SCHED_FAILGATE_EN.
module mm_cmd_scheduler
  import mm_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int START_CYC  = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*32-1:0]      req_cc_i,
  input  logic [NUM_REQ*33-1:0]      req_param_i,
  input  logic [NUM_REQ*8-1:0]       req_locality_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       resp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] resp_id_o,
  output logic [31:0]                resp_rc_o,
  input  logic                       resp_ready_i,
  output logic                       mm_keyStart_n_o,
  output logic [31:0]                mm_cc_o,
  output logic [32:0]                mm_param_o,
  output logic [7:0]                 mm_locality_o,
  input  logic [31:0]                mm_rc_i,
  input  logic [2:0]                 mm_op_state_i,
  output logic                       busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [15:0] START_LAST  = 16'(START_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  logic [1:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               rvalid_q, rvalid_d;
  logic [IW-1:0]      rid_q, rid_d;
  logic [31:0]        rc_q, rc_d;
  logic               key_n_q, key_n_d;
  logic [31:0]        cc_q, cc_d;
  logic [32:0]        param_q, param_d;
  logic [7:0]         loc_q, loc_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [31:0]        sel_cc;
  logic [32:0]        sel_param;
  logic [7:0]         sel_loc;
  logic               blocked;

  mm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign sel_cc    = req_cc_i[arb_idx*32 +: 32];
  assign sel_param = req_param_i[arb_idx*33 +: 33];
  assign sel_loc   = req_locality_i[arb_idx*8 +: 8];

`ifdef MM_SCHED_FAILGATE_EN
  assign blocked = (mm_op_state_i == OPSTATE_FAILURE) && !fail_exempt(sel_cc);
`else
  logic unused_op_state;
  assign unused_op_state = ^mm_op_state_i;
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    ready_d  = '0;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rc_d     = rc_q;
    key_n_d  = key_n_q;
    cc_d     = cc_q;
    param_d  = param_q;
    loc_d    = loc_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          ready_d = arb_gnt;
          ptr_d   = IW'((int'(arb_idx) + 1) % NUM_REQ);
          gnt_d   = arb_idx;
          cnt_d   = '0;
          // A blocked command answers immediately and leaves the mm_* port untouched.
          if (blocked) begin
            rvalid_d = 1'b1;
            rid_d    = arb_idx;
            rc_d     = RC_FAILURE;
            state_d  = ST_RESP;
          end else begin
            cc_d    = sel_cc;
            param_d = sel_param;
            loc_d   = sel_loc;
            key_n_d = 1'b0;
            state_d = ST_STROBE;
          end
        end
      end
      ST_STROBE: begin
        if (cnt_q == START_LAST) begin
          key_n_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          rvalid_d = 1'b1;
          rid_d    = gnt_q;
          rc_d     = mm_rc_i;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rvalid_q && resp_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      ready_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rc_q     <= '0;
      key_n_q  <= 1'b1;
      cc_q     <= '0;
      param_q  <= '0;
      loc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rc_q     <= rc_d;
      key_n_q  <= key_n_d;
      cc_q     <= cc_d;
      param_q  <= param_d;
      loc_q    <= loc_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign resp_valid_o    = rvalid_q;
  assign resp_id_o       = rid_q;
  assign resp_rc_o       = rc_q;
  assign mm_keyStart_n_o = key_n_q;
  assign mm_cc_o         = cc_q;
  assign mm_param_o      = param_q;
  assign mm_locality_o   = loc_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mm_cmd_scheduler.sv
// tb/tb_mm_cmd_scheduler.sv - directed self-checking bench for mm_cmd_scheduler
module tb_mm_cmd_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_cc;
  logic [N*33-1:0] req_param;
  logic [N*8-1:0]  req_loc;
  logic [N-1:0]  req_ready;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [31:0]   resp_rc;
  logic          resp_ready;
  logic          key_n;
  logic [31:0]   mm_cc;
  logic [32:0]   mm_param;
  logic [7:0]    mm_loc;
  logic [31:0]   mm_rc;
  logic [2:0]    op_state;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_cmd_scheduler #(.NUM_REQ(N), .START_CYC(2), .SETTLE_CYC(2)) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .req_valid_i     (req_valid),
    .req_cc_i        (req_cc),
    .req_param_i     (req_param),
    .req_locality_i  (req_loc),
    .req_ready_o     (req_ready),
    .resp_valid_o    (resp_valid),
    .resp_id_o       (resp_id),
    .resp_rc_o       (resp_rc),
    .resp_ready_i    (resp_ready),
    .mm_keyStart_n_o (key_n),
    .mm_cc_o         (mm_cc),
    .mm_param_o      (mm_param),
    .mm_locality_o   (mm_loc),
    .mm_rc_i         (mm_rc),
    .mm_op_state_i   (op_state),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] cc, input logic [7:0] loc);
    req_cc[32*k +: 32]    = cc;
    req_param[33*k +: 33] = {1'b1, cc};
    req_loc[8*k +: 8]     = loc;
  endtask

  task automatic wait_grant(input string tag);
    int w = 0;
    while (req_ready == '0 && w < 12) begin
      tick();
      w++;
    end
    chk(tag, 64'(w < 12), 64'd1);
  endtask

  task automatic wait_resp(input string tag);
    int w = 0;
    while (resp_valid !== 1'b1 && w < 12) begin
      tick();
      w++;
    end
    chk(tag, 64'(w < 12), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    rst        = 1'b1;
    req_valid  = '0;
    req_cc     = '0;
    req_param  = '0;
    req_loc    = '0;
    resp_ready = 1'b0;
    mm_rc      = 32'h0;
    op_state   = 3'b000;
    tick();
    tick();

    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rvalid", 64'(resp_valid), 64'h0);
    chk("rst_rid", 64'(resp_id), 64'h0);
    chk("rst_rc", 64'(resp_rc), 64'h0);
    chk("rst_keyn", 64'(key_n), 64'h1);
    chk("rst_cc", 64'(mm_cc), 64'h0);
    chk("rst_param", 64'(mm_param), 64'h0);
    chk("rst_loc", 64'(mm_loc), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    tick();

    // Single command: 5 cycles from request to response
    set_req(0, 32'h144, 8'h01);
    req_param[32:0] = 33'h0;
    req_valid = 4'b0001;
    tick();
    chk("s_ready", 64'(req_ready), 64'h1);
    chk("s_keyn0", 64'(key_n), 64'h0);
    chk("s_cc", 64'(mm_cc), 64'h144);
    chk("s_loc", 64'(mm_loc), 64'h01);
    chk("s_busy", 64'(busy), 64'h1);
    req_valid = 4'b0000;
    set_req(0, 32'hDEAD, 8'h77);
    tick();
    chk("s_keyn1", 64'(key_n), 64'h0);
    chk("s_ready_pulse", 64'(req_ready), 64'h0);
    chk("s_cc_latched", 64'(mm_cc), 64'h144);
    tick();
    chk("s_keyn_rel", 64'(key_n), 64'h1);
    tick();
    chk("s_rvalid_early", 64'(resp_valid), 64'h0);
    tick();
    chk("s_rvalid", 64'(resp_valid), 64'h1);
    chk("s_rid", 64'(resp_id), 64'h0);
    chk("s_rc", 64'(resp_rc), 64'h0);
    resp_ready = 1'b1;
    tick();
    chk("s_rvalid_clr", 64'(resp_valid), 64'h0);
    chk("s_idle", 64'(busy), 64'h0);
    chk("s_cc_kept", 64'(mm_cc), 64'h144);

    // Fairness: all valid, expect 0,1,2,3,0,1
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 32'h100 + 32'(k), 8'(k));
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_grant("f_wait_grant");
      exp_g = 4'b0001 << (n % N);
      chk("f_grant", 64'(req_ready), 64'(exp_g));
      chk("f_cc", 64'(mm_cc), 64'h100 + 64'(n % N));
      chk("f_keyn", 64'(key_n), 64'h0);
      wait_resp("f_wait_resp");
      chk("f_rid", 64'(resp_id), 64'(n % N));
      tick();
    end
    req_valid = 4'b0000;
    tick();

    // Backpressure: response held while requesters 1 and 2 wait
    do_reset();
    resp_ready = 1'b0;
    mm_rc = 32'hABCD1234;
    set_req(0, 32'h150, 8'h00);
    req_valid = 4'b0001;
    wait_grant("b_wait_grant0");
    chk("b_grant0", 64'(req_ready), 64'h1);
    req_valid = 4'b0110;
    wait_resp("b_wait_resp");
    chk("b_rc", 64'(resp_rc), 64'hABCD1234);
    mm_rc = 32'h0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("b_hold_valid", 64'(resp_valid), 64'h1);
      chk("b_hold_rc", 64'(resp_rc), 64'hABCD1234);
      chk("b_hold_ready", 64'(req_ready), 64'h0);
    end
    resp_ready = 1'b1;
    wait_grant("b_wait_grant1");
    chk("b_grant1", 64'(req_ready), 64'h2);
    req_valid = 4'b0000;
    wait_resp("b_wait_resp1");
    chk("b_rid1", 64'(resp_id), 64'h1);
    tick();
    tick();
    chk("b_withdrawn", 64'(busy), 64'h0);

    // Reset during STROBE (pointer is 2 before this grant)
    set_req(2, 32'h1F2, 8'h02);
    req_valid = 4'b0100;
    wait_grant("r_wait_grant");
    chk("r_grant", 64'(req_ready), 64'h4);
    req_valid = 4'b0000;
    tick();
    chk("r_keyn_low", 64'(key_n), 64'h0);
    rst = 1'b1;
    #1;
    chk("r_keyn_async", 64'(key_n), 64'h1);
    chk("r_busy_async", 64'(busy), 64'h0);
    chk("r_cc_async", 64'(mm_cc), 64'h0);
    tick();
    tick();
    chk("r_no_resp", 64'(resp_valid), 64'h0);
    rst = 1'b0;
    set_req(0, 32'h1A0, 8'h03);
    req_valid = 4'b1111;
    wait_grant("r_wait_grant2");
    chk("r_grant_ptr0", 64'(req_ready), 64'h1);
    req_valid = 4'b0000;
    wait_resp("r_wait_resp");
    tick();

    // Failure-mode stimulus (pointer is 1)
    op_state = 3'b101;
    mm_rc = 32'hFFFFFFFF;
    set_req(1, 32'h131, 8'h01);
    req_valid = 4'b0010;
    wait_grant("g_wait_grant");
    chk("g_grant", 64'(req_ready), 64'h2);
`ifdef MM_SCHED_FAILGATE_EN
    chk("g_no_strobe", 64'(key_n), 64'h1);
    chk("g_rvalid", 64'(resp_valid), 64'h1);
    chk("g_rc_fail", 64'(resp_rc), 64'h101);
    chk("g_rid", 64'(resp_id), 64'h1);
    chk("g_cc_kept", 64'(mm_cc), 64'h1A0);
    req_valid = 4'b0000;
    tick();
    chk("g_rvalid_clr", 64'(resp_valid), 64'h0);
    set_req(2, 32'h17C, 8'h02);
    req_valid = 4'b0100;
    wait_grant("g_wait_grant2");
    chk("g_grant2", 64'(req_ready), 64'h4);
    chk("g_exempt_strobe", 64'(key_n), 64'h0);
    req_valid = 4'b0000;
    wait_resp("g_wait_resp2");
    chk("g_rc_pass", 64'(resp_rc), 64'hFFFFFFFF);
`else
    chk("g_strobe", 64'(key_n), 64'h0);
    chk("g_cc", 64'(mm_cc), 64'h131);
    req_valid = 4'b0000;
    wait_resp("g_wait_resp");
    chk("g_rc_pass", 64'(resp_rc), 64'hFFFFFFFF);
    chk("g_rid", 64'(resp_id), 64'h1);
`endif
    tick();
    chk("g_idle", 64'(busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
